step_ctrl: RTL



---
 rtl/step_ctrl_pkg.sv | 21 ++
 rtl/step_ctrl_debounce.sv | 59 +++++
 rtl/step_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/step_ctrl_pkg.sv
// Shared types and default sizing for the picoNISC execution-clock controller.
// The state encoding is also what the board LEDs display.
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUN     = 2'd1,
        STEP    = 2'd2,
        HALTED  = 2'd3
    } ctrl_state_t;

    localparam int DIV_W_DEF    = 24;
    localparam int DB_TICKS_DEF = 4;
    localparam int CNT_W_DEF    = 16;

    // Stability counter only has to hold 0 .. ticks-1.
    function automatic int db_cnt_w(input int ticks);
        return (ticks <= 2) ? 1 : $clog2(ticks);
    endfunction

endpackage

// File: rtl/step_ctrl_debounce.sv
// Two-flop synchroniser followed by a tick-sampled stability filter for one
// raw board input. The debounced output only moves on a tick.
module step_ctrl_debounce
    import step_ctrl_pkg::*;
#(
    parameter int DB_TICKS = DB_TICKS_DEF
) (
    input  logic fastclk,
    input  logic nReset,
    input  logic tick,
    input  logic raw,
    output logic db
);

    localparam int CW = db_cnt_w(DB_TICKS);
    localparam logic [CW-1:0] LAST = CW'(DB_TICKS - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          db_q;
    logic          db_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The DB_TICKS-th consecutive differing sample flips the output.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        if (tick) begin
            if (sync2_q != db_q) begin
                if (cnt_q == LAST) begin
                    db_d  = sync2_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else begin
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge fastclk or negedge nReset) begin
        if (!nReset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db = db_q;

endmodule

// File: rtl/step_ctrl.sv
// CPU clock-enable generator: free-run on the divided tick, single-step from
// a debounced button, or halted on CPU request. Everything runs on fastclk.
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int DIV_W    = DIV_W_DEF,
    parameter int DB_TICKS = DB_TICKS_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic             fastclk,
    input  logic             nReset,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             halt,
    output logic             cpu_en,
    output logic             tick,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] step_count
);

    logic [DIV_W-1:0] div_q;
    logic [1:0]       raw_vec;
    logic [1:0]       db_vec;
    logic             run_db;
    logic             step_db;
    logic             step_prev_q;
    logic             step_rise;
    ctrl_state_t      state_q;
    logic             cpu_en_q;
    logic             en_d;
    logic [CNT_W-1:0] step_count_q;

    always_ff @(posedge fastclk or negedge nReset) begin
        if (!nReset) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    assign tick = &div_q;

    // Bit 0 is the run switch, bit 1 the step button.
    assign raw_vec = {step_btn, run_sw};

    for (genvar gi = 0; gi < 2; gi++) begin : g_db
        step_ctrl_debounce #(
            .DB_TICKS(DB_TICKS)
        ) u_db (
            .fastclk(fastclk),
            .nReset (nReset),
            .tick   (tick),
            .raw    (raw_vec[gi]),
            .db     (db_vec[gi])
        );
    end

    assign run_db    = db_vec[0];
    assign step_db   = db_vec[1];
    assign step_rise = step_db & ~step_prev_q;

    // Leaving RUN needs !run_db, which already blocks a coincident tick enable.
    always_comb begin
        en_d = ((state_q == RUN) && tick && !halt && run_db) ||
               ((state_q == STEP) && !halt);
    end

    // The counter advances on the same edge that raises cpu_en, so it already
    // includes the pulse while cpu_en is high.
    always_ff @(posedge fastclk or negedge nReset) begin
        if (!nReset) begin
            state_q      <= STOPPED;
            cpu_en_q     <= 1'b0;
            step_count_q <= '0;
            step_prev_q  <= 1'b0;
        end else begin
            step_prev_q <= step_db;
            cpu_en_q    <= en_d;
            if (en_d) begin
                step_count_q <= step_count_q + CNT_W'(1);
            end
            case (state_q)
                STOPPED: begin
                    if (halt)           state_q <= HALTED;
                    else if (run_db)    state_q <= RUN;
                    else if (step_rise) state_q <= STEP;
                end
                RUN: begin
                    if (halt)         state_q <= HALTED;
                    else if (!run_db) state_q <= STOPPED;
                end
                STEP: begin
                    state_q <= halt ? HALTED : STOPPED;
                end
                HALTED: begin
                    if (!run_db && !halt) state_q <= STOPPED;
                end
                default: state_q <= STOPPED;
            endcase
        end
    end

    assign cpu_en     = cpu_en_q;
    assign state      = state_q;
    assign step_count = step_count_q;

endmodule
